hit_mem_responder: RTL and testbench
====================================

// Module: hit_mem_responder
// PURPOSE
//  Memory-side responder for the hit-counting system. Serves single-cycle
//  mem_read / mem_write strobes from the counting controller against a 64-entry
//  hit-count RAM and returns read_done / write_done pulses. Also provides a
//  whole-memory clear sweep. Sits between the controller and the count RAM.
// PARAMETERS
//  ADDR_W  6   address width; depth = 2**ADDR_W entries
//  DATA_W  16  count word width
//  RD_LAT  2   cycles from accepted mem_read to read_done (>=1)
//  WR_LAT  1   cycles from accepted mem_write to write_done (>=1)
// PORTS
//  clk         in   1       system clock; single clock domain
//  rst_n       in   1       synchronous reset, active low
//  mem_read    in   1       read request strobe
//  mem_write   in   1       write request strobe
//  addr        in   ADDR_W  entry address, sampled with the strobe
//  wdata       in   DATA_W  write data, sampled with mem_write
//  clear_all   in   1       start clear sweep (zero every entry)
//  rdata       out  DATA_W  read data; valid with read_done, held until next read
//  read_done   out  1       one-cycle pulse: read complete
//  write_done  out  1       one-cycle pulse: write or clear sweep complete
//  busy        out  1       high while any operation is in flight
//  err         out  1       sticky: request dropped (collision or overrun)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state->IDLE, rdata=0, read_done=0,
//    write_done=0, busy=0, err=0, latency counter=0. RAM contents untouched.
//    Reset mid-operation aborts it: no done pulse, any pending write is lost.
//  - FSM states: IDLE, RD_WAIT, WR_WAIT, CLR.
//  - IDLE: strobes sampled at posedge. Priority clear_all > mem_read >
//    mem_write. clear_all->CLR; mem_read->RD_WAIT (latch addr);
//    mem_write->WR_WAIT (latch addr, wdata). When more than one request
//    is asserted in the same cycle, the lower-priority requests are dropped
//    and err is set.
//  - busy = (state != IDLE); it rises the cycle after acceptance.
//  - RD_WAIT: counter counts to RD_LAT. The RAM read uses the latched address.
//    At accept cycle T+RD_LAT: rdata is updated, read_done=1 for one cycle,
//    and the FSM returns to IDLE. A new strobe is accepted in the cycle after
//    read_done (back-to-back spacing is RD_LAT+1).
//  - WR_WAIT: the RAM is written at the first WR_WAIT cycle. At T+WR_LAT:
//    write_done=1 for one cycle, and the FSM returns to IDLE.
//  - CLR: writes 0 to entries 0..2**ADDR_W-1, one entry per cycle, in
//    ascending order. Sweep address wraps 2**ADDR_W-1 -> done; no wrap-around
//    rewrite. write_done pulses in the cycle after the last entry is written.
//  - Any strobe arriving while busy=1 is ignored, and err is set (overrun).
//  - err clears only on reset.
//  - Address is ADDR_W bits; no out-of-range case. Data is stored verbatim;
//    the responder does no arithmetic on counts.
//  - Outputs are registered; there are no combinational paths from inputs to
//    outputs.
// STRUCTURE
//  - Shared package count_sys_pkg: ADDR_W/DATA_W defaults, responder
//    state enum, CNT_MAX address constant (6'h3F).
//  - Sub-module hit_mem_ram: single-port synchronous RAM (1-cycle read,
//    write-enable), instantiated once. FSM, latency counter, and clear
//    sweep counter live in the top level.
// TESTING
//  - Write addr=6'h05, wdata=16'h0003 -> write_done exactly 1 cycle after
//    accept; then read addr 5 -> read_done at T+2, rdata=16'h0003.
//  - clear_all after filling all 64 entries with 16'hFFFF -> busy for 64
//    cycles, one write_done; subsequent reads of 0, 6'h1F, 6'h3F return 0.
//  - mem_read and mem_write asserted in the same cycle (addr 7) -> read
//    served, no write_done, RAM[7] unchanged, err=1.
//  - mem_read again while in RD_WAIT -> ignored, single read_done, err=1.
//  - rst_n low during RD_WAIT -> no read_done, rdata=0, busy=0, err=0; RAM
//    contents from before reset read back intact.
//  - Controller-style sequence read/modify/write of addr 6'h3F, repeated 3x
//    starting at 0 -> final read returns 16'h0003.

Source files
------------

// File: rtl/count_sys_pkg.sv
// Shared definitions for the hit-counting system: default widths,
// responder FSM states and the top entry address.
package count_sys_pkg;

   localparam int DEF_ADDR_W = 6;
   localparam int DEF_DATA_W = 16;

   // Highest entry address for the default 64-entry count RAM
   localparam logic [DEF_ADDR_W-1:0] CNT_MAX = 6'h3F;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WR_WAIT = 2'd2,
      ST_CLR     = 2'd3
   } resp_state_t;

endpackage

// File: rtl/hit_mem_ram.sv
// Single-port synchronous count RAM: registered read, write-enable.
// A read in the same cycle as a write to that entry returns the old word.
module hit_mem_ram #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Storage write and registered read; contents are never reset
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      q <= mem[addr];
   end

endmodule

// File: rtl/hit_mem_responder.sv
// Memory-side responder: serves read/write strobes and a clear sweep
// against the count RAM, returning registered done pulses.
module hit_mem_responder
   import count_sys_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int RD_LAT = 2,
   parameter int WR_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              clear_all,
   output logic [DATA_W-1:0] rdata,
   output logic              read_done,
   output logic              write_done,
   output logic              busy,
   output logic              err
);

   localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   localparam int CNT_W   = $clog2(LAT_MAX + 1);
   localparam logic [CNT_W-1:0]  RD_END    = CNT_W'(RD_LAT);
   localparam logic [CNT_W-1:0]  WR_END    = CNT_W'(WR_LAT);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [ADDR_W-1:0] SWEEP_END = '1;

   resp_state_t       state, state_nxt;
   logic [CNT_W-1:0]  lat_cnt, lat_cnt_nxt;
   logic [ADDR_W-1:0] sweep, sweep_nxt, addr_q, addr_q_nxt, ram_addr;
   logic [DATA_W-1:0] wdata_q, wdata_q_nxt, rdata_nxt, ram_wdata, ram_q;
   logic              read_done_nxt, write_done_nxt, err_nxt, ram_we;
   logic              any_req, multi_req;

   assign any_req   = mem_read | mem_write | clear_all;
   assign multi_req = (clear_all & (mem_read | mem_write)) | (mem_read & mem_write);
   assign busy      = (state != ST_IDLE);

   // Reset must also suppress a write landing on the same edge
   hit_mem_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
      .clk   (clk),
      .we    (ram_we & rst_n),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .q     (ram_q)
   );

   // State, latency/sweep counters, latched request and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         lat_cnt    <= '0;
         sweep      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata      <= '0;
         read_done  <= 1'b0;
         write_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_nxt;
         lat_cnt    <= lat_cnt_nxt;
         sweep      <= sweep_nxt;
         addr_q     <= addr_q_nxt;
         wdata_q    <= wdata_q_nxt;
         rdata      <= rdata_nxt;
         read_done  <= read_done_nxt;
         write_done <= write_done_nxt;
         err        <= err_nxt;
      end
   end

   // Next-state, RAM control and next values of the registered outputs
   always_comb begin
      state_nxt      = state;
      lat_cnt_nxt    = lat_cnt;
      sweep_nxt      = sweep;
      addr_q_nxt     = addr_q;
      wdata_q_nxt    = wdata_q;
      rdata_nxt      = rdata;
      read_done_nxt  = 1'b0;
      write_done_nxt = 1'b0;
      err_nxt        = err;
      ram_we         = 1'b0;
      ram_addr       = addr_q;
      ram_wdata      = wdata_q;
      case (state)
         ST_IDLE: begin
            // The RAM's read register captures the requested entry on the
            // accept edge; RD_WAIT then keeps it addressed via addr_q, so
            // any RD_LAT >= 1 finds the word ready.
            ram_addr = addr;
            if (multi_req) err_nxt = 1'b1;
            if (clear_all) begin
               state_nxt = ST_CLR;
               sweep_nxt = '0;
            end else if (mem_read) begin
               state_nxt   = ST_RD_WAIT;
               addr_q_nxt  = addr;
               lat_cnt_nxt = CNT_ONE;
            end else if (mem_write) begin
               state_nxt   = ST_WR_WAIT;
               addr_q_nxt  = addr;
               wdata_q_nxt = wdata;
               lat_cnt_nxt = CNT_ONE;
            end
         end
         ST_RD_WAIT: begin
            if (any_req) err_nxt = 1'b1;
            if (lat_cnt == RD_END) begin
               rdata_nxt     = ram_q;
               read_done_nxt = 1'b1;
               state_nxt     = ST_IDLE;
            end else begin
               lat_cnt_nxt = lat_cnt + CNT_ONE;
            end
         end
         ST_WR_WAIT: begin
            if (any_req) err_nxt = 1'b1;
            ram_we = (lat_cnt == CNT_ONE);
            if (lat_cnt == WR_END) begin
               write_done_nxt = 1'b1;
               state_nxt      = ST_IDLE;
            end else begin
               lat_cnt_nxt = lat_cnt + CNT_ONE;
            end
         end
         ST_CLR: begin
            if (any_req) err_nxt = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = sweep;
            ram_wdata = '0;
            sweep_nxt = sweep + ADDR_W'(1);
            if (sweep == SWEEP_END) begin
               write_done_nxt = 1'b1;
               state_nxt      = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_hit_mem_responder.sv
// Directed bench for hit_mem_responder: latency, clear sweep, collisions,
// overrun, reset abort and a read/modify/write sequence.
module tb_hit_mem_responder;
   import count_sys_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read, mem_write, clear_all;
   logic [5:0]  addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        read_done, write_done, busy, err;

   int nvec = 0;
   int nmis = 0;

   hit_mem_responder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .addr       (addr),
      .wdata      (wdata),
      .clear_all  (clear_all),
      .rdata      (rdata),
      .read_done  (read_done),
      .write_done (write_done),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Issue one request at a negedge, then watch outputs on following
   // negedges until a done pulse (bounded). lat = cycles from accept edge
   // to done edge; -1 on timeout. One extra cycle catches repeat pulses.
   task automatic run_op(input logic rd, input logic wr, input logic clr, input logic inj,
                         input logic [5:0] a, input logic [15:0] d,
                         output int lat, output int nbusy, output int nrd, output int nwr);
      int  n;
      bit  seen;
      n = 0; nbusy = 0; nrd = 0; nwr = 0; lat = -1; seen = 0;
      mem_read = rd; mem_write = wr; clear_all = clr; addr = a; wdata = d;
      while (!seen && n < 200) begin
         @(negedge clk);
         n++;
         if (busy) nbusy++;
         if (read_done) nrd++;
         if (write_done) nwr++;
         if (read_done || write_done) begin
            seen = 1;
            lat  = n - 1;
         end
         mem_read  = (n == 1) ? inj : 1'b0;
         mem_write = 1'b0;
         clear_all = 1'b0;
      end
      mem_read = 1'b0;
      @(negedge clk);
      if (read_done) nrd++;
      if (write_done) nwr++;
   endtask

   task automatic do_write(input logic [5:0] a, input logic [15:0] d);
      int lat, nb, nr, nw;
      run_op(0, 1, 0, 0, a, d, lat, nb, nr, nw);
   endtask

   task automatic do_read(input logic [5:0] a, output logic [15:0] v);
      int lat, nb, nr, nw;
      run_op(1, 0, 0, 0, a, 16'h0, lat, nb, nr, nw);
      v = rdata;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int lat, nb, nr, nw, extra;
      logic [15:0] v;
      rst_n = 1'b0; mem_read = 0; mem_write = 0; clear_all = 0; addr = '0; wdata = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_rdata", rdata, 0);
      chk("rst_rd_done", read_done, 0);
      chk("rst_wr_done", write_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // write then read back with exact latencies
      run_op(0, 1, 0, 0, 6'h05, 16'h0003, lat, nb, nr, nw);
      chk("wr_lat", lat, 1);
      chk("wr_busy", nb, 1);
      chk("wr_ndone", nw, 1);
      chk("wr_nrd", nr, 0);
      run_op(1, 0, 0, 0, 6'h05, 16'h0, lat, nb, nr, nw);
      chk("rd_lat", lat, 2);
      chk("rd_busy", nb, 2);
      chk("rd_ndone", nr, 1);
      chk("rd_data", rdata, 16'h0003);
      chk("rd_err", err, 0);

      // fill, then clear sweep
      for (int i = 0; i < 64; i++) do_write(6'(i), 16'hFFFF);
      do_read(6'h2A, v);
      chk("fill_2a", v, 16'hFFFF);
      run_op(0, 0, 1, 0, 6'h00, 16'h0, lat, nb, nr, nw);
      chk("clr_lat", lat, 64);
      chk("clr_busy", nb, 64);
      chk("clr_ndone", nw, 1);
      chk("clr_nrd", nr, 0);
      do_read(6'h00, v);   chk("clr_00", v, 0);
      do_read(6'h1F, v);   chk("clr_1f", v, 0);
      do_read(CNT_MAX, v); chk("clr_3f", v, 0);
      do_read(6'h20, v);   chk("clr_20", v, 0);
      chk("clr_err", err, 0);

      // read+write collision at addr 7
      do_write(6'h07, 16'h0077);
      run_op(1, 1, 0, 0, 6'h07, 16'hBEEF, lat, nb, nr, nw);
      chk("col_nrd", nr, 1);
      chk("col_nwr", nw, 0);
      chk("col_data", rdata, 16'h0077);
      chk("col_err", err, 1);
      do_read(6'h07, v);
      chk("col_ram7", v, 16'h0077);

      // overrun: second read while in RD_WAIT
      do_reset();
      @(negedge clk);
      chk("rst2_err", err, 0);
      do_write(6'h09, 16'h1234);
      run_op(1, 0, 0, 1, 6'h09, 16'h0, lat, nb, nr, nw);
      chk("ovr_nrd", nr, 1);
      chk("ovr_lat", lat, 2);
      chk("ovr_data", rdata, 16'h1234);
      chk("ovr_err", err, 1);

      // reset during RD_WAIT
      do_write(6'h0A, 16'hA5A5);
      mem_read = 1'b1; addr = 6'h0A;
      @(negedge clk);
      mem_read = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rab_rd_done", read_done, 0);
      chk("rab_rdata", rdata, 0);
      chk("rab_busy", busy, 0);
      chk("rab_err", err, 0);
      rst_n = 1'b1;
      extra = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (read_done) extra++;
      end
      chk("rab_no_done", extra, 0);
      do_read(6'h0A, v); chk("rab_ram0a", v, 16'hA5A5);
      do_read(6'h09, v); chk("rab_ram09", v, 16'h1234);

      // controller-style read/modify/write of top entry
      do_write(CNT_MAX, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         do_read(CNT_MAX, v);
         do_write(CNT_MAX, v + 16'h0001);
      end
      do_read(CNT_MAX, v);
      chk("rmw_final", v, 16'h0003);
      chk("rmw_err", err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
